// File: rtl/kd_tree_config_loader.sv
// KD-tree node configuration sequencer and root patch gate.
// Optional `CFG_CHECK_EN: flags config words whose split index exceeds 4.
module kd_tree_config_loader #(
   parameter int NUM_NODES     = 31,
   parameter int ADDR_WIDTH    = 5,
   parameter int STORAGE_WIDTH = 22
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [STORAGE_WIDTH-1:0] cfg_wdata,
   output logic [NUM_NODES-1:0]     node_wen,
   output logic [STORAGE_WIDTH-1:0] node_wdata,
   output logic [ADDR_WIDTH:0]      load_count,
   output logic                     loading,
   output logic                     done,
   input  logic                     patch_valid_in,
   output logic                     patch_ready_out,
   output logic                     patch_valid_out,
   output logic                     cfg_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN
   } state_t;

   localparam logic [ADDR_WIDTH:0] LAST_IDX =
      (ADDR_WIDTH+1)'(NUM_NODES - 1);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [ADDR_WIDTH:0]      r_load_count;
   logic [ADDR_WIDTH:0]      w_count_nxt;
   logic [NUM_NODES-1:0]     r_node_wen;
   logic [NUM_NODES-1:0]     w_wen_nxt;
   logic [STORAGE_WIDTH-1:0] r_node_wdata;
   logic [STORAGE_WIDTH-1:0] w_wdata_nxt;
   logic                     w_is_load;
   logic                     w_is_run;
   logic                     w_hs;

   assign w_is_load = (r_state == S_LOAD);
   assign w_is_run  = (r_state == S_RUN);
   // start has priority: a restart never swallows a word
   assign w_hs      = w_is_load & cfg_valid & ~start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_load_count;
      w_wen_nxt   = '0;
      w_wdata_nxt = r_node_wdata;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_LOAD;
               w_count_nxt = '0;
            end
         end
         S_LOAD: begin
            if (start) begin
               w_count_nxt = '0;
            end else if (w_hs) begin
               w_wdata_nxt = cfg_wdata;
               w_count_nxt = r_load_count + 1'b1;
               for (int n = 0; n < NUM_NODES; n++) begin
                  w_wen_nxt[n] =
                     (r_load_count == (ADDR_WIDTH+1)'(n));
               end
               if (r_load_count == LAST_IDX) begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (start) begin
               w_state_nxt = S_LOAD;
               w_count_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_count <= '0;
         r_node_wen   <= '0;
         r_node_wdata <= '0;
      end else begin
         r_load_count <= w_count_nxt;
         r_node_wen   <= w_wen_nxt;
         r_node_wdata <= w_wdata_nxt;
      end
   end

`ifdef CFG_CHECK_EN
   logic r_cfg_err;
   logic w_bad_idx;

   // only five feature dimensions exist in the tree
   assign w_bad_idx = (cfg_wdata[10:0] > 11'd4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg_err <= 1'b0;
      end else if (start) begin
         r_cfg_err <= 1'b0;
      end else if (w_hs & w_bad_idx) begin
         r_cfg_err <= 1'b1;
      end
   end

   assign cfg_err = r_cfg_err;
`else
   assign cfg_err = 1'b0;
`endif

   assign cfg_ready       = w_is_load & ~start;
   assign node_wen        = r_node_wen;
   assign node_wdata      = r_node_wdata;
   assign load_count      = r_load_count;
   assign loading         = w_is_load;
   assign done            = w_is_run;
   assign patch_ready_out = w_is_run;
   assign patch_valid_out = w_is_run & patch_valid_in;

endmodule

// File: tb/tb_kd_tree_config_loader.sv
// Scoreboard bench for kd_tree_config_loader.
// Random config streams checked against a load/run behavioural model.
module tb_kd_tree_config_loader;

   localparam int NN = 31;
   localparam int AW = 5;
   localparam int SW = 22;
`ifdef CFG_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [SW-1:0] cfg_wdata;
   logic [NN-1:0] node_wen;
   logic [SW-1:0] node_wdata;
   logic [AW:0]   load_count;
   logic          loading;
   logic          done;
   logic          patch_valid_in;
   logic          patch_ready_out;
   logic          patch_valid_out;
   logic          cfg_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            idx;
      logic [SW-1:0] data;
   } exp_t;

   exp_t sb[$];

   bit            m_load;
   bit            m_done;
   bit            m_err;
   int            m_count;
   logic [SW-1:0] m_wdata;

   kd_tree_config_loader dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_wdata       (cfg_wdata),
      .node_wen        (node_wen),
      .node_wdata      (node_wdata),
      .load_count      (load_count),
      .loading         (loading),
      .done            (done),
      .patch_valid_in  (patch_valid_in),
      .patch_ready_out (patch_ready_out),
      .patch_valid_out (patch_valid_out),
      .cfg_err         (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [SW-1:0] rnd();
      return SW'($urandom);
   endfunction

   task automatic model_reset();
      m_load  = 1'b0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_count = 0;
      m_wdata = '0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_wen", 32'(node_wen), 32'd0);
      chk("rst_wdata", 32'(node_wdata), 32'd0);
      chk("rst_count", 32'(load_count), 32'd0);
      chk("rst_loading", 32'(loading), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("rst_patch_rdy", 32'(patch_ready_out), 32'd0);
      chk("rst_patch_vld", 32'(patch_valid_out), 32'd0);
   endtask

   // one clock of stimulus; model state is what the DUT holds this cycle
   task automatic step(input logic s, input logic v,
                       input logic pv, input logic [SW-1:0] d);
      bit acc;
      @(posedge clk);
      #1;
      start          = s;
      cfg_valid      = v;
      patch_valid_in = pv;
      cfg_wdata      = d;
      acc = m_load && !s && v;
      @(negedge clk);
      chk("cfg_ready", 32'(cfg_ready), 32'(m_load && !s));
      chk("loading", 32'(loading), 32'(m_load));
      chk("done", 32'(done), 32'(m_done));
      chk("patch_ready", 32'(patch_ready_out), 32'(m_done));
      chk("patch_valid_out", 32'(patch_valid_out), 32'(m_done && pv));
      chk("load_count", 32'(load_count), 32'(m_count));
      chk("wdata_hold", 32'(node_wdata), 32'(m_wdata));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      #1;
      if (s) begin
         m_load  = 1'b1;
         m_done  = 1'b0;
         m_count = 0;
         m_err   = 1'b0;
      end else if (acc) begin
         sb.push_back(exp_t'{idx: m_count, data: d});
         m_wdata = d;
         if (CHK && d[10:0] > 11'd4) m_err = 1'b1;
         m_count++;
         if (m_count == NN) begin
            m_load = 1'b0;
            m_done = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && node_wen != '0) begin
         logic [NN-1:0] ew;
         exp_t          e;
         if (sb.size() == 0) begin
            chk("wen_spurious", 32'(node_wen), 32'd0);
         end else begin
            e = sb.pop_front();
            ew = '0;
            ew[e.idx] = 1'b1;
            chk("node_wen", 32'(node_wen), 32'(ew));
            chk("node_wdata", 32'(node_wdata), 32'(e.data));
            if (e.idx == NN - 1) chk("done_at_last", 32'(done), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int i;
      logic [SW-1:0] d;
      rst_n = 1'b0;
      start = 1'b0;
      cfg_valid = 1'b0;
      patch_valid_in = 1'b0;
      cfg_wdata = '0;
      model_reset();
      #12;
      chk_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, rnd());
      step(1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < NN; k++) step(1'b0, 1'b1, 1'($urandom), rnd());
      for (int k = 0; k < 8; k++) step(1'b0, 1'($urandom), 1'(k % 2), rnd());

      step(1'b1, 1'b0, 1'b1, '0);
      i = 0;
      while (m_load && i < 200) begin
         d = rnd();
         if (m_count == 3) d[10:0] = 11'd5;
         step(1'b0, (i % 3) == 0, 1'($urandom), d);
         i++;
      end
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'($urandom), '0);

      step(1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1, rnd());
      step(1'b1, 1'b1, 1'b0, rnd());
      i = 0;
      while (m_load && i < 200) begin
         step(1'b0, 1'b1, 1'($urandom), rnd());
         i++;
      end

      step(1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b0, rnd());
      step(1'b0, 1'b0, 1'b0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      model_reset();
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, '0);
      i = 0;
      while (m_load && i < 300) begin
         step(1'b0, 1'($urandom), 1'($urandom), rnd());
         i++;
      end
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'(k % 2), rnd());

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
